// File: rtl/ecc_20_err_mon.sv
// ecc_20_err_mon: one-deep registered pass-through of ECC decoder results with
// saturating error counters, sticky flags, first-error capture and a registered irq.
module ecc_20_err_mon #(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit_err,
  input  logic                  in_dbit_err,
  input  logic                  in_ecc_fault,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_bad,
  input  logic                  err_clr,
  input  logic [2:0]            irq_en,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [2:0]            err_sticky,
  output logic [ADDR_WIDTH-1:0] cap_addr,
  output logic [1:0]            cap_type,
  output logic                  irq
);
  typedef enum logic {IDLE, CAPT} state_t;
  state_t state, state_next;
  logic accept, log_err;
  logic [2:0] flags, sticky_next;
  logic [CNT_WIDTH-1:0] cnt [3];
  assign flags       = {in_ecc_fault, in_dbit_err, in_sbit_err};
  assign in_rdy      = ~out_vld | out_rdy;
  assign accept      = in_vld & in_rdy;
  assign log_err     = accept & |flags;
  assign sticky_next = err_clr ? 3'b000 : err_sticky | (accept ? flags : 3'b000);
  assign sbit_cnt    = cnt[0];
  assign dbit_cnt    = cnt[1];
  assign fault_cnt   = cnt[2];
  always_ff @(posedge clk)
    if (!rst_n) begin
      out_vld  <= 1'b0;
      out_data <= '0;
      out_bad  <= 1'b0;
    end else if (accept) begin
      out_vld  <= 1'b1;
      out_data <= in_data;
      out_bad  <= in_dbit_err | in_ecc_fault;
    end else if (out_rdy) begin
      out_vld  <= 1'b0;
    end
  always_ff @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (!rst_n || err_clr) cnt[k] <= '0;
      else if (accept && flags[k] && !(&cnt[k])) cnt[k] <= cnt[k] + 1'b1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      err_sticky <= 3'b000;
      irq        <= 1'b0;
    end else begin
      err_sticky <= sticky_next;
      irq        <= |(sticky_next & irq_en);
    end
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_next;
  always_comb
    state_next = err_clr ? IDLE : (state == IDLE && log_err) ? CAPT : state;
  // Only the first error after a clear is captured; CAPT locks the registers.
  always_ff @(posedge clk)
    if (!rst_n || err_clr) begin
      cap_addr <= '0;
      cap_type <= 2'b00;
    end else if (state == IDLE && log_err) begin
      cap_addr <= in_addr;
      cap_type <= in_ecc_fault ? 2'b11 : in_dbit_err ? 2'b10 : 2'b01;
    end
endmodule

// File: tb/tb_ecc_20_err_mon.sv
// tb_ecc_20_err_mon: directed and random stimulus against a behavioural monitor model;
// output words go through a scoreboard queue checked by an independent monitor process.
module tb_ecc_20_err_mon;
  localparam int DW = 20, AW = 8, CW = 8, CMAX = (1 << CW) - 1;
  logic clk = 0, rst_n = 0, in_vld = 0, out_rdy = 0, err_clr = 0;
  logic in_sbit_err = 0, in_dbit_err = 0, in_ecc_fault = 0;
  logic [AW-1:0] in_addr = '0;
  logic [DW-1:0] in_data = '0;
  logic [2:0] irq_en = '0;
  logic in_rdy, out_vld, out_bad, irq;
  logic [DW-1:0] out_data;
  logic [CW-1:0] sbit_cnt, dbit_cnt, fault_cnt;
  logic [2:0] err_sticky;
  logic [AW-1:0] cap_addr;
  logic [1:0] cap_type;
  int nvec = 0, nfail = 0;
  bit run = 0;
  // reference model state
  logic [DW:0] q[$];
  bit m_ovld = 0, m_capd = 0, m_irq = 0;
  int m_cnt [3] = '{0, 0, 0};
  logic [2:0] m_stk = 0;
  logic [AW-1:0] m_caddr = 0;
  logic [1:0] m_ctype = 0;

  ecc_20_err_mon #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr),
    .in_data(in_data), .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
    .in_ecc_fault(in_ecc_fault), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_bad(out_bad), .err_clr(err_clr), .irq_en(irq_en), .sbit_cnt(sbit_cnt),
    .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt), .err_sticky(err_sticky),
    .cap_addr(cap_addr), .cap_type(cap_type), .irq(irq));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (run) begin
    chk("in_rdy", 32'(in_rdy), 32'(!m_ovld || out_rdy));
    chk("out_vld", 32'(out_vld), 32'(m_ovld));
    chk("sbit_cnt", 32'(sbit_cnt), m_cnt[0]);
    chk("dbit_cnt", 32'(dbit_cnt), m_cnt[1]);
    chk("fault_cnt", 32'(fault_cnt), m_cnt[2]);
    chk("err_sticky", 32'(err_sticky), 32'(m_stk));
    chk("cap_addr", 32'(cap_addr), 32'(m_caddr));
    chk("cap_type", 32'(cap_type), 32'(m_ctype));
    chk("irq", 32'(irq), 32'(m_irq));
    if (out_vld && out_rdy) begin
      if (q.size() == 0) chk("out_word_unexpected", 32'(out_vld), 32'(0));
      else chk("out_word", 32'({out_bad, out_data}), 32'(q.pop_front()));
    end
  end

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic step(input bit v, input logic [2:0] f, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit ordy, input bit clr, input bit rn);
    bit acc;
    in_vld = v; {in_ecc_fault, in_dbit_err, in_sbit_err} = f; in_addr = a; in_data = d;
    out_rdy = ordy; err_clr = clr; rst_n = rn;
    acc = v && (!m_ovld || ordy);
    @(posedge clk);
    if (!rn) begin
      q.delete(); m_ovld = 0; m_cnt = '{0, 0, 0}; m_stk = 0;
      m_caddr = 0; m_ctype = 0; m_capd = 0; m_irq = 0;
    end else begin
      if (acc) begin q.push_back({f[1] | f[2], d}); m_ovld = 1; end
      else if (ordy) m_ovld = 0;
      if (clr) begin
        m_cnt = '{0, 0, 0}; m_stk = 0; m_caddr = 0; m_ctype = 0; m_capd = 0;
      end else if (acc) begin
        for (int i = 0; i < 3; i++) m_cnt[i] = (m_cnt[i] + f[i] > CMAX) ? CMAX : m_cnt[i] + f[i];
        m_stk = m_stk | f;
        if (f != 0 && !m_capd) begin
          m_capd = 1; m_caddr = a;
          m_ctype = f[2] ? 2'd3 : f[1] ? 2'd2 : 2'd1;
        end
      end
      m_irq = |(m_stk & irq_en);
    end
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    run = 1;
    step(0, 0, 0, 0, 1, 0, 1);
    irq_en = 3'b001;
    for (int i = 0; i < 4; i++)
      step(1, i == 1 ? 3'b001 : 3'b000, i == 1 ? 8'h12 : 8'(i), DW'($urandom), 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 3'b001, 8'h20, DW'($urandom), 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 300; i++) step(1, 3'b001, 8'(i), DW'($urandom), 1, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1);
    irq_en = 3'b100;
    step(1, 3'b001, 8'h05, DW'($urandom), 1, 0, 1);
    step(1, 3'b100, 8'h06, DW'($urandom), 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    step(1, 3'b010, 8'h07, DW'($urandom), 1, 1, 1);
    step(0, 0, 0, 0, 1, 0, 1);
    irq_en = 3'b111;
    step(1, 3'b111, 8'h33, DW'($urandom), 0, 0, 1);
    step(1, 3'b011, 8'h34, DW'($urandom), 0, 0, 1);
    step(1, 3'b000, 8'h35, DW'($urandom), 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) irq_en = 3'($urandom);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0 ? 3'($urandom) : 3'b000,
           AW'($urandom), DW'($urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 199) != 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, 1);
    chk("drain", q.size(), 0);
    run = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
